fb_uart_dump: RTL and testbench
===============================

Name: fb_uart_dump

Overview:
Read-back engine for the processor's output frame buffer. The pipeline writes filtered pixels into the frame buffer. When the pipeline signals completion, this block walks the buffer from address 0 upward. It serialises each 8-bit pixel onto a UART TX line (8N1), preceded by a 2-byte sync header, so a host can capture the filtered image. It reads through a synchronous-read port of the frame buffer alongside the VGA scan port.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal values are 2 or more.
PIX_COUNT, 65536, number of pixels dumped, from address 0 to PIX_COUNT-1; legal range is 1 to 65536.
HDR0, 8'hA5, first sync header byte.
HDR1, 8'h5A, second sync header byte.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
i_start  input  1  dump request, level signal (tied to the pipeline completion flag); only its rising edge triggers a dump.
o_rd_addr  output  16  frame-buffer read address.
o_rd_en  output  1  read strobe, one cycle per pixel.
i_rd_data  input  8  frame-buffer read data, valid exactly 1 cycle after o_rd_en.
o_tx  output  1  UART serial out; idles high.
o_busy  output  1  high from the start edge until the last stop bit completes.
o_done  output  1  high after a complete dump until the next accepted start edge.

Behaviour:
- Reset is asynchronous and active-high. Clock is clk.
- Reset values: o_tx=1, o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0. FSM returns to IDLE; all counters clear.
- Start detection:
  - i_start is registered once and a rising edge is detected (i_start=1 and previous sample=0).
  - Edges while o_busy=1 are ignored.
  - A level that is held high does not retrigger.
  - If i_start is already high when rst releases, that is not an edge: the previous-sample register resets to 1.
- FSM states: IDLE, HDR_A, HDR_B, FETCH, WAIT, SEND, FIN.
  - IDLE: on an edge, o_busy=1, o_done=0, pixel counter=0, go to HDR_A.
  - HDR_A and HDR_B: load HDR0 then HDR1 into the shift register and transmit each as one full frame. After HDR_B, go to FETCH.
  - FETCH: o_rd_en=1 for one cycle with o_rd_addr=counter. Go to WAIT.
  - WAIT: on the next cycle, capture i_rd_data into the shift register. Go to SEND.
  - SEND: transmit one frame. On its completion, go to FIN if counter==PIX_COUNT-1; otherwise counter+1 and go to FETCH.
  - FIN: o_busy=0, o_done=1, go to IDLE.
- UART frame:
  - Order: start bit (0), then data bits 0..7 LSB first, then stop bit (1).
  - Every bit lasts exactly CLKS_PER_BIT cycles. One frame is 10*CLKS_PER_BIT cycles.
  - o_tx is registered and changes only on bit boundaries.
  - The first start bit begins exactly 2 cycles after the cycle that samples the i_start rising edge.
- Inter-byte gap:
  - No gap between the header bytes.
  - Between a header or pixel byte and the next pixel byte there is a 2-cycle idle-high gap (FETCH, WAIT).
- Address and width:
  - The counter is 17 bits internally so PIX_COUNT=65536 terminates correctly.
  - o_rd_addr takes the low 16 bits of the counter. It never wraps past PIX_COUNT-1.
- o_rd_addr holds its last value between reads.
- A start edge arriving in the same cycle as FIN is ignored.
- Reset mid-frame aborts immediately: o_tx=1 at once (asynchronous), no partial stop bit is completed, and the next edge restarts from the header.
- Total dump time from start edge to o_done is 2 + 10*CLKS_PER_BIT*(2+PIX_COUNT) + 2*PIX_COUNT + 1 cycles.

Test Plan:
- Reset idle: assert rst mid-run, then release with i_start=0 -> o_tx=1, o_busy=0, o_done=0, o_rd_en=0 on every cycle for 100 cycles.
- Basic dump: CLKS_PER_BIT=4, PIX_COUNT=4, memory {0x00,0xFF,0x3C,0x81}, pulse i_start -> a UART monitor decodes A5,5A,00,FF,3C,81. o_rd_addr sequence is 0,1,2,3. o_done rises 1+2+10*4*6+8 = 251 cycles after the edge.
- Bit timing: CLKS_PER_BIT=4 -> every o_tx transition lands on a multiple of 4 cycles from the start-bit edge. The stop bit is high for exactly 4 cycles before the 2-cycle gap.
- Level start: hold i_start=1 through and after completion -> exactly one dump; o_done stays 1 and no second header appears. Drop i_start, raise it again -> a second full dump, with o_done cleared on the edge.
- Busy retrigger: toggle i_start 0->1->0->1 during the pixel-2 frame -> the output stream is identical to the basic dump, with no extra bytes.
- Reset mid-pixel: assert rst during data bit 3 of pixel 1 -> o_tx=1 in the same cycle. After release plus a new edge, the stream restarts at A5 and the full 6 bytes are correct.

Source files
------------

// File: rtl/fb_uart_dump.sv
// fb_uart_dump: walks the frame buffer after a start edge and streams a sync header plus every pixel out as 8N1 UART.
module fb_uart_dump #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         PIX_COUNT    = 65536,
  parameter logic [7:0] HDR0         = 8'hA5,
  parameter logic [7:0] HDR1         = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic [15:0] o_rd_addr,
  output logic        o_rd_en,
  input  logic [7:0]  i_rd_data,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, HDR_A, HDR_B, FETCH, WAIT, SEND, FIN} state_t;
  state_t          state_q, state_d;
  logic [16:0]     pix_q, pix_d;
  logic            busy_q, busy_d, done_q, done_d, prev_q;
  logic            act_q, act_d, tx_q, tx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bno_q, bno_d;
  logic [7:0]      sh_q, sh_d, ld_byte;
  logic            load, tick, fdone, start_edge;
  assign start_edge = i_start & ~prev_q;
  assign tick       = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign fdone      = act_q & tick & (bno_q == 4'd9);
  assign o_rd_addr  = pix_q[15:0];
  assign o_rd_en    = state_q == FETCH;
  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    busy_d  = busy_q;
    done_d  = done_q;
    load    = 1'b0;
    ld_byte = HDR0;
    case (state_q)
      IDLE: if (start_edge && !busy_q) begin
        state_d = HDR_A;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pix_d   = '0;
      end
      HDR_A: if (!act_q) load = 1'b1;
      else if (fdone) begin
        load    = 1'b1;
        ld_byte = HDR1;
        state_d = HDR_B;
      end
      HDR_B: state_d = fdone ? FETCH : HDR_B;
      FETCH: state_d = WAIT;
      WAIT: begin
        load    = 1'b1;
        ld_byte = i_rd_data;
        state_d = SEND;
      end
      SEND: if (fdone) begin
        state_d = pix_q == 17'(PIX_COUNT - 1) ? FIN : FETCH;
        pix_d   = pix_q == 17'(PIX_COUNT - 1) ? pix_q : pix_q + 17'd1;
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Loading drives the start bit on the next cycle; each boundary shifts out the next LSB, then the stop bit.
  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    bno_d = bno_q;
    sh_d  = sh_q;
    tx_d  = tx_q;
    if (load) begin
      act_d = 1'b1;
      cnt_d = '0;
      bno_d = '0;
      sh_d  = ld_byte;
      tx_d  = 1'b0;
    end else if (act_q) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        bno_d = bno_q + 4'd1;
        sh_d  = sh_q >> 1;
        tx_d  = bno_q < 4'd8 ? sh_q[0] : 1'b1;
        act_d = bno_q != 4'd9;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prev_q  <= 1'b1;
      act_q   <= 1'b0;
      cnt_q   <= '0;
      bno_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prev_q  <= i_start;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      bno_q   <= bno_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_fb_uart_dump.sv
// tb_fb_uart_dump: per-cycle waveform model of the dump plus literal checks on decoded bytes, addresses and latency.
module tb_fb_uart_dump;
  localparam int C = 4;
  localparam int P = 4;
  typedef struct packed {logic tx; logic busy; logic rd; logic [15:0] addr;} ent_t;
  logic        clk = 0, rst = 1, i_start = 0;
  logic [15:0] o_rd_addr;
  logic        o_rd_en, o_tx, o_busy, o_done;
  logic [7:0]  i_rd_data = 8'hEE;
  logic [7:0]  mem [P] = '{8'h00, 8'hFF, 8'h3C, 8'h81};
  logic [7:0]  exp_bytes [6] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h3C, 8'h81};
  int          checks = 0, errors = 0;
  ent_t        q[$];
  logic        done_m = 0, prev_m = 1;
  logic [7:0]  got[$];
  logic [15:0] addrs[$];
  bit          mact = 0;
  logic        mprev = 1;
  int          mcnt = 0;
  logic [7:0]  msh = 0;

  fb_uart_dump #(.CLKS_PER_BIT(C), .PIX_COUNT(P), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en),
    .i_rd_data(i_rd_data), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  // Synchronous-read frame buffer; garbage outside the valid cycle exposes a mistimed capture.
  always @(posedge clk) i_rd_data <= o_rd_en ? mem[o_rd_addr[1:0]] : 8'hEE;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int k = 0; k < 10; k++)
      repeat (C) q.push_back('{k == 0 ? 1'b0 : (k == 9 ? 1'b1 : b[k-1]), 1'b1, 1'b0, 16'd0});
  endtask

  task automatic build();
    q.push_back('{1'b1, 1'b1, 1'b0, 16'd0});
    push_frame(8'hA5);
    push_frame(8'h5A);
    for (int i = 0; i < P; i++) begin
      q.push_back('{1'b1, 1'b1, 1'b1, 16'(i)});
      q.push_back('{1'b1, 1'b1, 1'b0, 16'd0});
      push_frame(mem[i]);
    end
    q.push_back('{1'b1, 1'b1, 1'b0, 16'd0});
  endtask

  // Queue front is the current cycle; an edge is only taken in a cycle with nothing scheduled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      done_m = 0;
      prev_m = 1;
    end else begin
      if (q.size() != 0) begin
        void'(q.pop_front());
        if (q.size() == 0) done_m = 1;
      end else if (i_start && !prev_m) begin
        done_m = 0;
        build();
      end
      prev_m = i_start;
    end
  end

  always @(negedge clk) begin
    ent_t e;
    logic de;
    e  = q.size() != 0 ? q[0] : '{1'b1, 1'b0, 1'b0, 16'd0};
    de = q.size() != 0 ? 1'b0 : done_m;
    chk("tx", o_tx, e.tx);
    chk("busy", o_busy, e.busy);
    chk("done", o_done, de);
    chk("rd_en", o_rd_en, e.rd);
    if (e.rd) chk("rd_addr", o_rd_addr, e.addr);
    if (o_rd_en) addrs.push_back(o_rd_addr);
  end

  always @(negedge clk) begin
    if (rst) begin
      mact = 0;
      mprev = 1;
    end else begin
      if (!mact) begin
        if (mprev && !o_tx) begin mact = 1; mcnt = 0; end
      end else begin
        mcnt++;
        if (mcnt % C == C / 2 && mcnt >= C + C / 2 && mcnt <= 8 * C + C / 2) msh = {o_tx, msh[7:1]};
        if (mcnt == 10 * C - 1) begin mact = 0; got.push_back(msh); end
      end
      mprev = o_tx;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_done && n < 1000);
    if (!o_done) chk("done_timeout", 0, 1);
    #2;
  endtask

  task automatic check_stream(input string nm);
    chk({nm, "_nbytes"}, got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk({nm, "_byte"}, got[i], exp_bytes[i]);
    got.delete();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 0;
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_tx", o_tx, 1);
    repeat (100) tick();
    // basic dump with literal latency and address order
    addrs.delete();
    i_start = 1;
    wait_done(n);
    chk("done_latency", n, 251);
    chk("n_addrs", addrs.size(), 4);
    for (int i = 0; i < 4 && i < addrs.size(); i++) chk("addr_seq", addrs[i], i);
    check_stream("basic");
    // level held: no retrigger
    repeat (300) tick();
    chk("level_done_held", o_done, 1);
    chk("level_no_bytes", got.size(), 0);
    i_start = 0;
    repeat (2) tick();
    i_start = 1;
    tick();
    chk("redump_done_clr", o_done, 0);
    chk("redump_busy", o_busy, 1);
    wait_done(n);
    check_stream("redump");
    // toggling during pixel-2 frame
    i_start = 0;
    tick();
    i_start = 1;
    repeat (175) tick();
    i_start = 0; tick();
    i_start = 1; tick();
    i_start = 0; tick();
    i_start = 1;
    wait_done(n);
    check_stream("retrig");
    // reset during data bit 3 of pixel 1
    i_start = 0;
    tick();
    i_start = 1;
    repeat (143) tick();
    rst = 1;
    #1;
    chk("midrst_tx", o_tx, 1);
    chk("midrst_busy", o_busy, 0);
    i_start = 0;
    repeat (3) tick();
    rst = 0;
    got.delete();
    tick();
    i_start = 1;
    wait_done(n);
    chk("restart_latency", n, 251);
    check_stream("restart");
    i_start = 0;
    repeat (100) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
